peripheral_uart_rx_ctrl_wb: RTL and testbench

Sequencing controller for the Wishbone UART receive FIFO (11-bit entries: data[10:3], break[2], parity[1], framing[0]). It turns host RBR/LSR reads into FIFO pops and status clears, and holds the registered RBR value. It also derives the LSR receive bits and generates the three receive interrupt sources: RX data available (trigger level), character timeout, and line status. It sits between the register file and the RX FIFO.

---
 rtl/mpsoc_uart_wb_pkg.sv | 37 +++
 rtl/peripheral_uart_rx_timeout_wb.sv | 102 ++++++++++
 rtl/peripheral_uart_rx_ctrl_wb.sv | 141 ++++++++++++++
 tb/tb_peripheral_uart_rx_ctrl_wb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_uart_wb_pkg.sv
// Shared constants for the Wishbone UART receive path: trigger encodings,
// RX FIFO head field layout and timeout FSM state encodings.
package mpsoc_uart_wb_pkg;

    localparam logic [1:0] TRIG_1  = 2'b00;
    localparam logic [1:0] TRIG_4  = 2'b01;
    localparam logic [1:0] TRIG_8  = 2'b10;
    localparam logic [1:0] TRIG_14 = 2'b11;

    localparam logic [7:0] LVL_1  = 8'd1;
    localparam logic [7:0] LVL_4  = 8'd4;
    localparam logic [7:0] LVL_8  = 8'd8;
    localparam logic [7:0] LVL_14 = 8'd14;

    localparam int HEAD_DATA_LSB = 3;
    localparam int HEAD_BI       = 2;
    localparam int HEAD_PE       = 1;
    localparam int HEAD_FE       = 0;

    typedef logic [1:0] to_state_t;
    localparam to_state_t TO_IDLE  = 2'd0;
    localparam to_state_t TO_COUNT = 2'd1;
    localparam to_state_t TO_FIRED = 2'd2;

    function automatic logic [7:0] rx_trig_level(input logic [1:0] trig);
        logic [7:0] lvl;
        case (trig)
            TRIG_1:  lvl = LVL_1;
            TRIG_4:  lvl = LVL_4;
            TRIG_8:  lvl = LVL_8;
            TRIG_14: lvl = LVL_14;
            default: lvl = LVL_1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/peripheral_uart_rx_timeout_wb.sv
// Character-timeout detector: counts idle bit periods while the RX FIFO holds
// data and raises int_cti once TO_CHARS frames pass with no push or pop.
module peripheral_uart_rx_timeout_wb
    import mpsoc_uart_wb_pkg::*;
#(
    parameter int TO_CHARS = 4
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic       clr,
    input  logic       count_nz,
    input  logic       bit_tick,
    input  logic       rx_push,
    input  logic       fifo_pop,
    input  logic [3:0] frame_bits,
    output logic       int_cti
);

    to_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  frame_c_s;
    logic [5:0]  thr_s;
    logic        activity_s;

    // Threshold in bit periods, with out-of-range frame lengths treated as 12.
    always_comb begin
        if ((frame_bits < 4'd7) || (frame_bits > 4'd12)) begin
            frame_c_s = 4'd12;
        end else begin
            frame_c_s = frame_bits;
        end
        thr_s      = 6'(TO_CHARS) * {2'b00, frame_c_s};
        activity_s = rx_push | fifo_pop;
    end

    // Next-state and counter logic; a FIFO reset overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = TO_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                TO_IDLE: begin
                    cnt_d = 6'd0;
                    if (count_nz) begin
                        state_d = TO_COUNT;
                    end else begin
                        state_d = TO_IDLE;
                    end
                end
                TO_COUNT: begin
                    if (!count_nz) begin
                        state_d = TO_IDLE;
                        cnt_d   = 6'd0;
                    end else if (activity_s) begin
                        cnt_d = 6'd0;
                    end else if (bit_tick) begin
                        if (cnt_q == (thr_s - 6'd1)) begin
                            state_d = TO_FIRED;
                        end else begin
                            state_d = TO_COUNT;
                        end
                        cnt_d = (cnt_q == 6'h3F) ? cnt_q : (cnt_q + 6'd1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                TO_FIRED: begin
                    if (!count_nz) begin
                        state_d = TO_IDLE;
                        cnt_d   = 6'd0;
                    end else if (activity_s) begin
                        state_d = TO_COUNT;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = TO_FIRED;
                    end
                end
                default: begin
                    state_d = TO_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= TO_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign int_cti = (state_q == TO_FIRED);

endmodule

// File: rtl/peripheral_uart_rx_ctrl_wb.sv
// RX FIFO sequencing for the Wishbone UART: RBR/LSR read handling, sticky LSR
// error bits and the three receive interrupt sources.
module peripheral_uart_rx_ctrl_wb
    import mpsoc_uart_wb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_COUNTER_W = 5,
    parameter int TO_CHARS       = 4
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      rbr_rd,
    input  logic                      lsr_rd,
    input  logic [1:0]                fcr_trig,
    input  logic                      fcr_rx_reset,
    input  logic [3:0]                frame_bits,
    input  logic                      bit_tick,
    input  logic                      rx_push,
    input  logic [FIFO_COUNTER_W-1:0] fifo_count,
    input  logic [10:0]               fifo_head,
    input  logic                      fifo_overrun,
    output logic                      fifo_pop,
    output logic                      fifo_reset,
    output logic                      fifo_reset_status,
    output logic [7:0]                rbr_data,
    output logic                      lsr_dr,
    output logic                      lsr_oe,
    output logic                      lsr_pe,
    output logic                      lsr_fe,
    output logic                      lsr_bi,
    output logic                      lsr_rfe,
    output logic                      int_rda,
    output logic                      int_cti,
    output logic                      int_rls
);

    logic       count_nz_s, pop_s;
    logic [7:0] level_s, count_ext_s;
    logic       set_pe_s, set_fe_s, set_bi_s;
    logic [7:0] rbr_data_q, rbr_data_d;
    logic       fifo_reset_q, fifo_reset_d;
    logic       pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
    logic       rfe_q, rfe_d;
    logic       head_masked_q, head_masked_d;

    // Occupancy decode and trigger level, capped at the FIFO capacity.
    always_comb begin
        count_nz_s  = (fifo_count != '0);
        pop_s       = rbr_rd & count_nz_s;
        count_ext_s = 8'(fifo_count);
        level_s     = rx_trig_level(fcr_trig);
        if (level_s > 8'(FIFO_DEPTH)) begin
            level_s = 8'(FIFO_DEPTH);
        end else begin
            level_s = level_s;
        end
    end

    // Error flags from the head entry; a head already reported via LSR is masked.
    always_comb begin
        set_pe_s = count_nz_s & fifo_head[HEAD_PE] & ~head_masked_q;
        set_fe_s = count_nz_s & fifo_head[HEAD_FE] & ~head_masked_q;
        set_bi_s = count_nz_s & fifo_head[HEAD_BI] & ~head_masked_q;
    end

    // Next values for RBR holding register, reset strobe and sticky LSR bits.
    always_comb begin
        rbr_data_d   = pop_s ? fifo_head[10:HEAD_DATA_LSB] : rbr_data_q;
        fifo_reset_d = fcr_rx_reset;
        if (fifo_reset_q) begin
            pe_d          = 1'b0;
            fe_d          = 1'b0;
            bi_d          = 1'b0;
            rfe_d         = 1'b0;
            head_masked_d = 1'b0;
        end else begin
            pe_d  = lsr_rd ? 1'b0 : (pe_q | set_pe_s);
            fe_d  = lsr_rd ? 1'b0 : (fe_q | set_fe_s);
            bi_d  = lsr_rd ? 1'b0 : (bi_q | set_bi_s);
            rfe_d = lsr_rd ? (pe_d | fe_d | bi_d)
                           : (rfe_q | set_pe_s | set_fe_s | set_bi_s);
            // A head change unseen by the host must be evaluated even if LSR was read.
            if (pop_s || (rx_push && !count_nz_s)) begin
                head_masked_d = 1'b0;
            end else if (lsr_rd) begin
                head_masked_d = 1'b1;
            end else begin
                head_masked_d = head_masked_q;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rbr_data_q    <= 8'h00;
            fifo_reset_q  <= 1'b0;
            pe_q          <= 1'b0;
            fe_q          <= 1'b0;
            bi_q          <= 1'b0;
            rfe_q         <= 1'b0;
            head_masked_q <= 1'b0;
        end else begin
            rbr_data_q    <= rbr_data_d;
            fifo_reset_q  <= fifo_reset_d;
            pe_q          <= pe_d;
            fe_q          <= fe_d;
            bi_q          <= bi_d;
            rfe_q         <= rfe_d;
            head_masked_q <= head_masked_d;
        end
    end

    peripheral_uart_rx_timeout_wb #(
        .TO_CHARS (TO_CHARS)
    ) u_timeout (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .clr        (fifo_reset_q),
        .count_nz   (count_nz_s),
        .bit_tick   (bit_tick),
        .rx_push    (rx_push),
        .fifo_pop   (pop_s),
        .frame_bits (frame_bits),
        .int_cti    (int_cti)
    );

    assign fifo_pop          = pop_s;
    assign fifo_reset        = fifo_reset_q;
    assign fifo_reset_status = lsr_rd;
    assign rbr_data          = rbr_data_q;
    assign lsr_dr            = count_nz_s;
    assign lsr_oe            = fifo_overrun;
    assign lsr_pe            = pe_q;
    assign lsr_fe            = fe_q;
    assign lsr_bi            = bi_q;
    assign lsr_rfe           = rfe_q;
    assign int_rda           = count_nz_s & (count_ext_s >= level_s);
    assign int_rls           = fifo_overrun | pe_q | fe_q | bi_q;

endmodule

// File: tb/tb_peripheral_uart_rx_ctrl_wb.sv
// Directed bench for peripheral_uart_rx_ctrl_wb with a small behavioural RX FIFO.
module tb_peripheral_uart_rx_ctrl_wb;
    import mpsoc_uart_wb_pkg::*;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        rbr_rd, lsr_rd, fcr_rx_reset, bit_tick, rx_push;
    logic [1:0]  fcr_trig;
    logic [3:0]  frame_bits;
    logic [10:0] fifo_in;
    logic [4:0]  fifo_count;
    logic [10:0] fifo_head;
    logic        fifo_overrun;
    logic        fifo_pop, fifo_reset, fifo_reset_status;
    logic [7:0]  rbr_data;
    logic        lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi, lsr_rfe;
    logic        int_rda, int_cti, int_rls;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    peripheral_uart_rx_ctrl_wb #(
        .FIFO_DEPTH     (16),
        .FIFO_COUNTER_W (5),
        .TO_CHARS       (4)
    ) dut (
        .clk               (clk),
        .wb_rst_i          (wb_rst_i),
        .rbr_rd            (rbr_rd),
        .lsr_rd            (lsr_rd),
        .fcr_trig          (fcr_trig),
        .fcr_rx_reset      (fcr_rx_reset),
        .frame_bits        (frame_bits),
        .bit_tick          (bit_tick),
        .rx_push           (rx_push),
        .fifo_count        (fifo_count),
        .fifo_head         (fifo_head),
        .fifo_overrun      (fifo_overrun),
        .fifo_pop          (fifo_pop),
        .fifo_reset        (fifo_reset),
        .fifo_reset_status (fifo_reset_status),
        .rbr_data          (rbr_data),
        .lsr_dr            (lsr_dr),
        .lsr_oe            (lsr_oe),
        .lsr_pe            (lsr_pe),
        .lsr_fe            (lsr_fe),
        .lsr_bi            (lsr_bi),
        .lsr_rfe           (lsr_rfe),
        .int_rda           (int_rda),
        .int_cti           (int_cti),
        .int_rls           (int_rls)
    );

    // Behavioural RX FIFO driven by the DUT's pop/reset strobes.
    logic [10:0] mem [0:15];
    logic [3:0]  wp, rp;
    logic [4:0]  cnt;
    logic        ovr;
    logic        push_ok;
    assign push_ok      = rx_push && ((cnt < 5'd16) || fifo_pop);
    assign fifo_count   = cnt;
    assign fifo_head    = mem[rp];
    assign fifo_overrun = ovr;

    always @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0; ovr <= 1'b0;
        end else if (fifo_reset) begin
            wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0; ovr <= 1'b0;
        end else begin
            if (fifo_pop) rp <= rp + 4'd1;
            if (push_ok) begin
                mem[wp] <= fifo_in;
                wp      <= wp + 4'd1;
            end
            cnt <= cnt + {4'd0, push_ok} - {4'd0, fifo_pop};
            if (rx_push && !push_ok) ovr <= 1'b1;
            else if (fifo_reset_status) ovr <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [10:0] e);
        @(negedge clk);
        rx_push = 1'b1;
        fifo_in = e;
        @(negedge clk);
        rx_push = 1'b0;
        #1;
    endtask

    task automatic rbr_read();
        @(negedge clk);
        rbr_rd = 1'b1;
        @(negedge clk);
        rbr_rd = 1'b0;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_tick = 1'b1;
            @(negedge clk);
            bit_tick = 1'b0;
        end
        #1;
    endtask

    initial begin
        wb_rst_i = 1'b1;
        rbr_rd = 1'b0; lsr_rd = 1'b0; fcr_rx_reset = 1'b0; bit_tick = 1'b0;
        rx_push = 1'b0; fifo_in = 11'h000; fcr_trig = 2'b01; frame_bits = 4'd10;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        #1;
        chk("rst_rbr", rbr_data, 8'h00);
        chk("rst_dr", {7'd0, lsr_dr}, 8'd0);
        chk("rst_rda", {7'd0, int_rda}, 8'd0);
        chk("rst_cti", {7'd0, int_cti}, 8'd0);
        chk("rst_rls", {7'd0, int_rls}, 8'd0);
        chk("rst_state", {6'd0, dut.u_timeout.state_q}, {6'd0, TO_IDLE});

        // Trigger level 4
        push({8'h41, 3'b000});
        push({8'h42, 3'b000});
        push({8'h43, 3'b000});
        chk("rda_at3", {7'd0, int_rda}, 8'd0);
        push({8'h44, 3'b000});
        chk("rda_at4", {7'd0, int_rda}, 8'd1);
        chk("dr_at4", {7'd0, lsr_dr}, 8'd1);
        @(negedge clk);
        rbr_rd = 1'b1;
        #1;
        chk("pop_on_rd", {7'd0, fifo_pop}, 8'd1);
        @(negedge clk);
        rbr_rd = 1'b0;
        #1;
        chk("pop_pulse_end", {7'd0, fifo_pop}, 8'd0);
        chk("rbr_41", rbr_data, 8'h41);
        chk("count_3", {3'd0, fifo_count}, 8'd3);
        chk("rda_after_pop", {7'd0, int_rda}, 8'd0);
        rbr_read();
        rbr_read();
        rbr_read();
        chk("rbr_44", rbr_data, 8'h44);
        chk("dr_empty", {7'd0, lsr_dr}, 8'd0);

        // Empty read
        @(negedge clk);
        rbr_rd = 1'b1;
        #1;
        chk("pop_empty", {7'd0, fifo_pop}, 8'd0);
        @(negedge clk);
        rbr_rd = 1'b0;
        #1;
        chk("rbr_hold", rbr_data, 8'h44);
        chk("idle_empty", {6'd0, dut.u_timeout.state_q}, {6'd0, TO_IDLE});

        // Character timeout: 4 * 10 bit ticks
        push({8'h55, 3'b000});
        @(negedge clk);
        ticks(39);
        chk("cti_39", {7'd0, int_cti}, 8'd0);
        ticks(1);
        chk("cti_40", {7'd0, int_cti}, 8'd1);
        chk("fired", {6'd0, dut.u_timeout.state_q}, {6'd0, TO_FIRED});
        rbr_read();
        chk("cti_clr", {7'd0, int_cti}, 8'd0);
        chk("rbr_55", rbr_data, 8'h55);
        @(negedge clk);
        #1;
        chk("idle_after_cti", {6'd0, dut.u_timeout.state_q}, {6'd0, TO_IDLE});

        // Error head: parity + break, data 0x80
        push(11'h406);
        push({8'h33, 3'b000});
        @(negedge clk);
        #1;
        chk("pe_set", {7'd0, lsr_pe}, 8'd1);
        chk("bi_set", {7'd0, lsr_bi}, 8'd1);
        chk("fe_clr", {7'd0, lsr_fe}, 8'd0);
        chk("rfe_set", {7'd0, lsr_rfe}, 8'd1);
        chk("rls_set", {7'd0, int_rls}, 8'd1);
        @(negedge clk);
        lsr_rd = 1'b1;
        #1;
        chk("rst_status", {7'd0, fifo_reset_status}, 8'd1);
        @(negedge clk);
        lsr_rd = 1'b0;
        @(negedge clk);
        #1;
        chk("pe_masked", {7'd0, lsr_pe}, 8'd0);
        chk("bi_masked", {7'd0, lsr_bi}, 8'd0);
        chk("rfe_masked", {7'd0, lsr_rfe}, 8'd0);
        chk("rls_masked", {7'd0, int_rls}, 8'd0);
        rbr_read();
        chk("rbr_80", rbr_data, 8'h80);
        @(negedge clk);
        #1;
        chk("pe_clean_head", {7'd0, lsr_pe}, 8'd0);
        chk("bi_clean_head", {7'd0, lsr_bi}, 8'd0);
        rbr_read();
        chk("rbr_33", rbr_data, 8'h33);

        // FCR RX reset mid-timeout with 5 entries (first one framing error)
        push(11'h001);
        push({8'h01, 3'b000});
        push({8'h02, 3'b000});
        push({8'h03, 3'b000});
        push({8'h04, 3'b000});
        ticks(5);
        chk("fe_set", {7'd0, lsr_fe}, 8'd1);
        @(negedge clk);
        fcr_rx_reset = 1'b1;
        @(negedge clk);
        fcr_rx_reset = 1'b0;
        #1;
        chk("fifo_reset_pulse", {7'd0, fifo_reset}, 8'd1);
        @(negedge clk);
        #1;
        chk("fifo_reset_end", {7'd0, fifo_reset}, 8'd0);
        chk("idle_after_frst", {6'd0, dut.u_timeout.state_q}, {6'd0, TO_IDLE});
        chk("fe_after_frst", {7'd0, lsr_fe}, 8'd0);
        chk("rfe_after_frst", {7'd0, lsr_rfe}, 8'd0);
        chk("dr_after_frst", {7'd0, lsr_dr}, 8'd0);

        // Async reset while fired (frame_bits=7 -> 28 ticks)
        frame_bits = 4'd7;
        push(11'h001);
        @(negedge clk);
        ticks(28);
        chk("cti_28", {7'd0, int_cti}, 8'd1);
        chk("fe_pre_rst", {7'd0, lsr_fe}, 8'd1);
        @(posedge clk);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("arst_cti", {7'd0, int_cti}, 8'd0);
        chk("arst_fe", {7'd0, lsr_fe}, 8'd0);
        chk("arst_rfe", {7'd0, lsr_rfe}, 8'd0);
        chk("arst_rls", {7'd0, int_rls}, 8'd0);
        chk("arst_rbr", rbr_data, 8'h00);
        chk("arst_dr", {7'd0, lsr_dr}, 8'd0);
        chk("arst_pop", {7'd0, fifo_pop}, 8'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
